// File: rtl/fifo_burst_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_burst_arbiter
//
// Round-robin burst arbiter draining several first-word-fall-through FIFOs
// into one downstream port. A channel is granted for up to MAX_BURST words,
// then the pointer moves past it and one idle bubble separates bursts.
//
// Parameters
//   WIDTH      number of requesting FIFO channels
//   DATA_W     word width
//   MAX_BURST  maximum words per grant (1..255)
//
// Ports
//   BUS_CLK     in   clock, rising edge
//   BUS_RST_N   in   asynchronous active-low reset
//   ENABLE      in   [WIDTH]         per-channel arbitration enable
//   FIFO_EMPTY  in   [WIDTH]         per-channel empty flag
//   FIFO_DATA   in   [WIDTH*DATA_W]  channel i word at [i*DATA_W +: DATA_W]
//   FIFO_READ   out  [WIDTH]         per-channel pop strobe
//   READY_OUT   in                   downstream can accept a word
//   WRITE_OUT   out                  DATA_OUT valid and accepted this cycle
//   DATA_OUT    out  [DATA_W]        forwarded word
//   GRANT       out  [WIDTH]         registered one-hot owner, zero when idle
//   BUSY        out                  high while bursting
//   WORD_CNT    out  [32]            total words forwarded (wraps)
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no owner; pick next eligible channel starting at ptr
// S_BURST | channel g owns the port; forward words until limit or drop-out
// ---------------------------------------------------------------------------
module fifo_burst_arbiter #(
  parameter int WIDTH     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST_N,
  input  logic [WIDTH-1:0]        ENABLE,
  input  logic [WIDTH-1:0]        FIFO_EMPTY,
  input  logic [WIDTH*DATA_W-1:0] FIFO_DATA,
  output logic [WIDTH-1:0]        FIFO_READ,
  input  logic                    READY_OUT,
  output logic                    WRITE_OUT,
  output logic [DATA_W-1:0]       DATA_OUT,
  output logic [WIDTH-1:0]        GRANT,
  output logic                    BUSY,
  output logic [31:0]             WORD_CNT
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  g_q, g_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0]  grant_q, grant_d;

  logic [WIDTH-1:0]  eligible;
  logic [DATA_W-1:0] words [WIDTH];
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_found;
  logic              in_burst;
  logic              cur_elig;
  logic              write_out;
  logic [IDX_W-1:0]  g_next;

  assign eligible  = ENABLE & ~FIFO_EMPTY;
  assign in_burst  = (state_q == S_BURST);
  assign cur_elig  = ENABLE[g_q] & ~FIFO_EMPTY[g_q];
  assign write_out = in_burst & READY_OUT & cur_elig;
  assign g_next    = (g_q == LAST_IDX) ? '0 : g_q + 1'b1;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      words[i] = FIFO_DATA[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: first eligible channel at ptr, ptr+1, ... mod WIDTH.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= WIDTH) begin
        cand = cand - WIDTH;
      end
      cand_idx = IDX_W'(cand);
      if (!sel_found && eligible[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d          = S_BURST;
          g_d              = sel_idx;
          bcnt_d           = '0;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
        end
      end
      S_BURST: begin
        if (write_out) begin
          bcnt_d = bcnt_q + 8'd1;
        end
        // Owner dropped out (empty or disabled) or burst limit reached.
        if (!cur_elig || (write_out && (bcnt_q == LAST_BEAT))) begin
          state_d = S_IDLE;
          ptr_d   = g_next;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign word_cnt_d = word_cnt_q + 32'(write_out);

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q    <= S_IDLE;
      g_q        <= '0;
      ptr_q      <= '0;
      bcnt_q     <= '0;
      grant_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      ptr_q      <= ptr_d;
      bcnt_q     <= bcnt_d;
      grant_q    <= grant_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    FIFO_READ      = '0;
    FIFO_READ[g_q] = write_out;
  end

  assign WRITE_OUT = write_out;
  assign DATA_OUT  = in_burst ? words[g_q] : '0;
  assign GRANT     = grant_q;
  assign BUSY      = in_burst;
  assign WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_arbiter
//
// Directed bench for fifo_burst_arbiter. Per-channel FIFOs are modelled as
// queues; each directed case pushes its expected output words (data, owner
// channel, cycle gap from the previous write) into a scoreboard queue, and
// an independent negedge monitor pops and compares on every WRITE_OUT.
// ---------------------------------------------------------------------------
module tb_fifo_burst_arbiter;

  localparam int WIDTH     = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 16;

  logic                    BUS_CLK    = 1'b0;
  logic                    BUS_RST_N  = 1'b1;
  logic [WIDTH-1:0]        ENABLE     = '0;
  logic [WIDTH-1:0]        FIFO_EMPTY = '1;
  logic [WIDTH*DATA_W-1:0] FIFO_DATA  = '0;
  logic [WIDTH-1:0]        FIFO_READ;
  logic                    READY_OUT  = 1'b0;
  logic                    WRITE_OUT;
  logic [DATA_W-1:0]       DATA_OUT;
  logic [WIDTH-1:0]        GRANT;
  logic                    BUSY;
  logic [31:0]             WORD_CNT;

  fifo_burst_arbiter #(
    .WIDTH    (WIDTH),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .BUS_CLK   (BUS_CLK),
    .BUS_RST_N (BUS_RST_N),
    .ENABLE    (ENABLE),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA (FIFO_DATA),
    .FIFO_READ (FIFO_READ),
    .READY_OUT (READY_OUT),
    .WRITE_OUT (WRITE_OUT),
    .DATA_OUT  (DATA_OUT),
    .GRANT     (GRANT),
    .BUSY      (BUSY),
    .WORD_CNT  (WORD_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  typedef struct {
    logic [31:0] data;
    int          ch;
    int          gap;
  } exp_t;

  exp_t             expq [$];
  logic [31:0]      fq [WIDTH][$];
  int               wr_idx [WIDTH];
  int               rd_idx [WIDTH];
  int               errors = 0;
  int               checks = 0;
  int               exp_wc = 0;
  int               cyc = 0;
  int               last_wr = 0;
  logic [WIDTH-1:0] pend_rd = '0;

  function automatic logic [31:0] mk_word(int ch, int idx);
    return {8'hA0 + 8'(ch), 8'h5C, 16'(idx)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every forwarded word against the scoreboard.
  always @(negedge BUS_CLK) begin
    exp_t e;
    cyc++;
    check("grant_onehot0", 32'($onehot0(GRANT)), 32'd1);
    pend_rd = FIFO_READ;
    if (WRITE_OUT === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: data 0x%08h grant %b, expected no write", DATA_OUT, GRANT);
      end else begin
        e = expq.pop_front();
        check("data_out", DATA_OUT, e.data);
        check("write_grant", 32'(GRANT), 32'(1 << e.ch));
        check("fifo_read", 32'(FIFO_READ), 32'(1 << e.ch));
        if (e.gap != 0) begin
          check("write_gap", 32'(cyc - last_wr), 32'(e.gap));
        end
      end
      last_wr = cyc;
    end else if (FIFO_READ !== '0) begin
      checks++;
      errors++;
      $display("FAIL stray_fifo_read: got %b, expected 0000", FIFO_READ);
    end
  end

  // FIFO model: apply pops seen by the monitor, then present FWFT outputs.
  always @(posedge BUS_CLK) begin
    #1;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_rd[i] && fq[i].size() > 0) begin
        void'(fq[i].pop_front());
      end
      FIFO_EMPTY[i] = (fq[i].size() == 0);
      FIFO_DATA[i*DATA_W +: DATA_W] = (fq[i].size() == 0) ? '0 : fq[i][0];
    end
  end

  task automatic step();
    @(posedge BUS_CLK);
    #2;
  endtask

  task automatic push(int ch, int n);
    repeat (n) begin
      fq[ch].push_back(mk_word(ch, wr_idx[ch]));
      wr_idx[ch]++;
    end
  endtask

  task automatic expect_words(int ch, int n, int first_gap, int rest_gap);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.data = mk_word(ch, rd_idx[ch]);
      e.ch   = ch;
      e.gap  = (k == 0) ? first_gap : rest_gap;
      rd_idx[ch]++;
      expq.push_back(e);
      exp_wc++;
    end
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d words still expected, expected 0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic wait_wc(string name, int target, int budget);
    int n = 0;
    while (WORD_CNT != 32'(target) && n < budget) begin
      step();
      n++;
    end
    if (WORD_CNT != 32'(target)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: WORD_CNT %0d, expected %0d", name, WORD_CNT, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int first;
    for (int i = 0; i < WIDTH; i++) begin
      wr_idx[i] = 0;
      rd_idx[i] = 0;
    end

    // Reset state
    #1 BUS_RST_N = 1'b0;
    step();
    step();
    check("rst_write_out", 32'(WRITE_OUT), 32'd0);
    check("rst_fifo_read", 32'(FIFO_READ), 32'd0);
    check("rst_grant", 32'(GRANT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_data_out", DATA_OUT, 32'd0);
    check("rst_word_cnt", WORD_CNT, 32'd0);
    check("rst_ptr", 32'(dut.ptr_q), 32'd0);
    BUS_RST_N = 1'b1;
    READY_OUT = 1'b1;
    step();

    // Round-robin fairness: 40 words each, 16-word bursts, 1-cycle bubble
    ENABLE = '0;
    for (int ch = 0; ch < WIDTH; ch++) push(ch, 40);
    step();
    ENABLE = '1;
    for (int r = 0; r < 3; r++) begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        if (r == 0 && ch == 0) first = 0;
        else if (r == 2 && ch > 0) first = 3;
        else first = 2;
        expect_words(ch, (r < 2) ? 16 : 8, first, 1);
      end
    end
    wait_drain("rr", 400);
    repeat (3) step();
    check("rr_word_cnt", WORD_CNT, 32'd160);
    check("rr_busy_end", 32'(BUSY), 32'd0);
    check("rr_grant_end", 32'(GRANT), 32'd0);

    // Early empty: ch2 only, 3 words
    ENABLE = 4'b0100;
    push(2, 3);
    expect_words(2, 3, 0, 1);
    wait_drain("early_empty", 50);
    repeat (3) step();
    check("ee_busy", 32'(BUSY), 32'd0);
    check("ee_grant", 32'(GRANT), 32'd0);
    check("ee_ptr", 32'(dut.ptr_q), 32'd3);
    check("ee_word_cnt", WORD_CNT, 32'd163);
    // ptr=3 means ch3 wins over ch0 next
    push(0, 1);
    push(3, 1);
    expect_words(3, 1, 0, 1);
    expect_words(0, 1, 3, 1);
    ENABLE = 4'b1001;
    wait_drain("ptr_order", 50);
    repeat (3) step();
    check("ptr_order_word_cnt", WORD_CNT, 32'd165);

    // Backpressure mid-burst on ch0
    ENABLE = 4'b0001;
    push(0, 20);
    base = exp_wc;
    expect_words(0, 5, 0, 1);
    expect_words(0, 11, 0, 1);
    expect_words(0, 4, 2, 1);
    wait_wc("bp_start", base + 5, 50);
    READY_OUT = 1'b0;
    repeat (10) begin
      #1;
      check("bp_fifo_read", 32'(FIFO_READ), 32'd0);
      check("bp_grant", 32'(GRANT), 32'b0001);
      check("bp_word_cnt", WORD_CNT, 32'(base + 5));
      step();
    end
    READY_OUT = 1'b1;
    wait_drain("bp", 100);
    repeat (3) step();
    check("bp_busy_end", 32'(BUSY), 32'd0);
    check("bp_word_cnt_end", WORD_CNT, 32'(exp_wc));

    // Enable drop mid-burst on ch1
    ENABLE = 4'b0110;
    push(1, 10);
    push(2, 4);
    base = exp_wc;
    expect_words(1, 3, 0, 1);
    expect_words(2, 4, 3, 1);
    expect_words(1, 7, 0, 1);
    wait_wc("ed_start", base + 3, 50);
    ENABLE = 4'b0100;
    #1;
    check("ed_write_stop", 32'(WRITE_OUT), 32'd0);
    check("ed_read_stop", 32'(FIFO_READ), 32'd0);
    check("ed_busy_same", 32'(BUSY), 32'd1);
    step();
    check("ed_busy_next", 32'(BUSY), 32'd0);
    check("ed_grant_next", 32'(GRANT), 32'd0);
    begin
      int n = 0;
      while (expq.size() > 7 && n < 60) begin
        step();
        n++;
      end
    end
    repeat (3) step();
    check("ed_ch1_skipped", 32'(BUSY), 32'd0);
    ENABLE = 4'b0110;
    wait_drain("ed", 80);
    repeat (3) step();
    check("ed_word_cnt", WORD_CNT, 32'(exp_wc));

    // Reset mid-burst: ch1 at bcnt=5
    ENABLE = 4'b0010;
    push(1, 10);
    push(3, 5);
    expect_words(1, 5, 0, 1);
    wait_wc("mr_start", exp_wc, 50);
    BUS_RST_N = 1'b0;
    #1;
    check("mr_write_out", 32'(WRITE_OUT), 32'd0);
    check("mr_fifo_read", 32'(FIFO_READ), 32'd0);
    check("mr_grant", 32'(GRANT), 32'd0);
    check("mr_busy", 32'(BUSY), 32'd0);
    check("mr_data_out", DATA_OUT, 32'd0);
    check("mr_word_cnt", WORD_CNT, 32'd0);
    exp_wc = 0;
    ENABLE = 4'b1010;
    repeat (3) step();
    check("mr_hold_busy", 32'(BUSY), 32'd0);
    check("mr_hold_grant", 32'(GRANT), 32'd0);
    expect_words(1, 5, 0, 1);
    expect_words(3, 5, 3, 1);
    BUS_RST_N = 1'b1;
    wait_drain("mr", 60);
    repeat (3) step();
    check("mr_word_cnt_end", WORD_CNT, 32'd10);

    // WORD_CNT wrap
    ENABLE = 4'b0001;
    force dut.word_cnt_q = 32'hFFFF_FFFE;
    step();
    step();
    release dut.word_cnt_q;
    #1;
    check("wrap_preload", WORD_CNT, 32'hFFFF_FFFE);
    push(0, 3);
    expect_words(0, 3, 0, 1);
    wait_drain("wrap", 50);
    repeat (3) step();
    check("wrap_word_cnt", WORD_CNT, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_burst_arbiter.md
FIFO_BURST_ARBITER -- requirements
Module: fifo_burst_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of requesting FIFO channels.
REQ-002 SHALL have parameter DATA_W, default 32: word width.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum words per grant, range 1..255.
REQ-004 SHALL have port BUS_CLK, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port BUS_RST_N, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port ENABLE, input, WIDTH: per-channel arbitration enable mask.
REQ-007 SHALL have port FIFO_EMPTY, input, WIDTH: per-channel empty flag from first-word-fall-through FIFOs.
REQ-008 SHALL have port FIFO_DATA, input, WIDTH*DATA_W: channel i word at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port FIFO_READ, output, WIDTH: per-channel pop strobe.
REQ-010 SHALL have port READY_OUT, input, 1: downstream can accept a word this cycle.
REQ-011 SHALL have port WRITE_OUT, output, 1: DATA_OUT valid and accepted this cycle.
REQ-012 SHALL have port DATA_OUT, output, DATA_W: forwarded word.
REQ-013 SHALL have port GRANT, output, WIDTH: registered one-hot current owner, all-zero when idle.
REQ-014 SHALL have port BUSY, output, 1: high while in BURST.
REQ-015 SHALL have port WORD_CNT, output, 32: total words forwarded.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and BURST, plus registers grant index g, rotate pointer ptr, burst counter bcnt (8 bit) and WORD_CNT.
REQ-017 SHALL define eligible[i] = ENABLE[i] & ~FIFO_EMPTY[i].
REQ-018 In IDLE, if any eligible bit is set, SHALL select the first eligible channel searching ptr, ptr+1, ... mod WIDTH, load g, clear bcnt and enter BURST on the next edge.
REQ-019 In IDLE, if no channel is eligible, SHALL remain in IDLE.
REQ-020 SHALL drive WRITE_OUT = BURST & READY_OUT & ~FIFO_EMPTY[g] & ENABLE[g], combinationally with zero latency.
REQ-021 SHALL drive FIFO_READ[g] = WRITE_OUT, and all other FIFO_READ bits 0.
REQ-022 SHALL drive DATA_OUT = FIFO_DATA word g whenever in BURST, and 0 in IDLE.
REQ-023 On each WRITE_OUT, SHALL increment bcnt and increment WORD_CNT, which wraps from 0xFFFFFFFF to 0.
REQ-024 SHALL leave BURST for IDLE when WRITE_OUT occurs with bcnt == MAX_BURST-1.
REQ-025 SHALL leave BURST for IDLE in any cycle where FIFO_EMPTY[g] or ~ENABLE[g], with no transfer in that cycle.
REQ-026 When READY_OUT is low and the channel is still eligible, SHALL stay in BURST holding g and bcnt, with no timeout.
REQ-027 On every BURST-to-IDLE transition, SHALL set ptr = (g+1) mod WIDTH.
REQ-028 SHALL insert one idle bubble cycle between bursts.
REQ-029 SHALL never grant two channels at once; GRANT is one-hot or zero.
REQ-030 SHALL drive BUSY high iff the state is BURST.

Reset
REQ-031 While BUS_RST_N is low, SHALL hold state IDLE, g=0, ptr=0, bcnt=0, WORD_CNT=0, GRANT=0, BUSY=0, WRITE_OUT=0, FIFO_READ=0 and DATA_OUT=0.
REQ-032 SHALL apply reset asynchronously, abandoning any in-progress burst with no partial pop after assertion.
REQ-033 After release, SHALL resume normal arbitration from ptr=0.

Verification
REQ-034 Reset mid-burst: assert BUS_RST_N low with ch1 at bcnt=5 -> all outputs 0 immediately; after release, the first grant goes to the lowest eligible index.
REQ-035 Round-robin fairness: all 4 channels hold 40 words, READY_OUT=1, MAX_BURST=16 -> grants ch0,1,2,3,0,... with 16 words each and a 1-cycle bubble; WORD_CNT=160 at the end.
REQ-036 Early empty: ch2 holds 3 words and is the only eligible channel -> 3 WRITE_OUTs, then IDLE, ptr=3, BUSY low.
REQ-037 Backpressure: READY_OUT=0 for 10 cycles mid-burst on ch0 -> no FIFO_READ, GRANT stays 0001, and the burst resumes at the same bcnt.
REQ-038 Enable drop: ENABLE[1] cleared mid-burst -> transfers stop that cycle, IDLE next cycle, and ch1 is skipped until re-enabled.
REQ-039 WORD_CNT wrap: preload WORD_CNT to 0xFFFFFFFE via force, then forward 3 words -> WORD_CNT=0x00000001.
